// File: rtl/reg_arb_pkg.sv
// Shared definitions for the register-table write arbiter and the statistics
// reporters that feed it.
package reg_arb_pkg;

    localparam int REG_AW  = 7;
    localparam int REG_DW  = 16;
    localparam int GRANT_W = 2;

    localparam logic [REG_AW-1:0] ADDR_RX_FLOW = 7'h10;
    localparam logic [REG_AW-1:0] ADDR_TX_FLOW = 7'h11;
    localparam logic [REG_AW-1:0] ADDR_ERR     = 7'h12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set bit of req searching upward from ptr,
// wrapping modulo N_REQ.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [GRANT_W-1:0] ptr,
    output logic               valid,
    output logic [GRANT_W-1:0] idx
);

    always_comb begin
        int j;
        valid = 1'b0;
        idx   = '0;
        j     = 0;
        // Walk offsets from farthest to nearest so the nearest hit is the one kept.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N_REQ;
            if (req[j]) begin
                valid = 1'b1;
                idx   = GRANT_W'(j);
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter sharing the register-table write port among N_REQ
// statistics writers, with a watchdog that aborts an unacknowledged write.
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int AW      = REG_AW,
    parameter int DW      = REG_DW,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_in,
    input  logic [N_REQ*AW-1:0] addr_in,
    input  logic [N_REQ*DW-1:0] din_in,
    output logic [N_REQ-1:0]   ack_out,
    output logic [AW-1:0]      reg_addr,
    output logic [DW-1:0]      reg_din,
    output logic               reg_req,
    input  logic               reg_ack,
    output logic [1:0]         grant_id,
    output logic               busy,
    output logic               timeout_pulse,
    output logic [7:0]         timeout_cnt,
    output logic [1:0]         dbg_state
);

    // Handshake: a writer holds req/addr/din until it sees its one-cycle ack;
    // toward the table, reg_req stays high with stable addr/din until reg_ack
    // is seen in ISSUE (or the watchdog fires), and reg_ack is ignored elsewhere.

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    arb_state_t          state_q, state_d;
    logic [GRANT_W-1:0]  ptr_q, ptr_d;
    logic [GRANT_W-1:0]  grant_q, grant_d;
    logic [AW-1:0]       addr_q, addr_d;
    logic [DW-1:0]       din_q, din_d;
    logic                req_q, req_d;
    logic [N_REQ-1:0]    ack_q, ack_d;
    logic                tpulse_q, tpulse_d;
    logic [7:0]          tcnt_q, tcnt_d;
    logic [7:0]          wd_q, wd_d;

    logic                pick_valid;
    logic [GRANT_W-1:0]  pick_idx;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (req_in),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            din_q    <= '0;
            req_q    <= 1'b0;
            ack_q    <= '0;
            tpulse_q <= 1'b0;
            tcnt_q   <= '0;
            wd_q     <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            tpulse_q <= tpulse_d;
            tcnt_q   <= tcnt_d;
            wd_q     <= wd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        din_d    = din_q;
        req_d    = req_q;
        ack_d    = '0;
        tpulse_d = 1'b0;
        tcnt_d   = tcnt_q;
        wd_d     = wd_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    addr_d  = addr_in[pick_idx*AW +: AW];
                    din_d   = din_in[pick_idx*DW +: DW];
                    req_d   = 1'b1;
                    wd_d    = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A real ack beats a simultaneous watchdog expiry.
                if (reg_ack) begin
                    req_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    state_d        = ST_ACK;
                end else if (wd_q == WD_LAST) begin
                    req_d          = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    tpulse_d       = 1'b1;
                    if (tcnt_q != 8'hFF) begin
                        tcnt_d = tcnt_q + 8'd1;
                    end
                    state_d        = ST_ACK;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            ST_ACK: begin
                ptr_d   = (grant_q == GRANT_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign ack_out       = ack_q;
    assign reg_addr      = addr_q;
    assign reg_din       = din_q;
    assign reg_req       = req_q;
    assign grant_id      = grant_q;
    assign busy          = (state_q != ST_IDLE);
    assign timeout_pulse = tpulse_q;
    assign timeout_cnt   = tcnt_q;
    assign dbg_state     = state_q;

endmodule
